// File: rtl/gray_binary.sv
// Gray-to-binary receiver: decodes each accepted code, classifies the step from
// the previous code (up/down/repeat/illegal), counts illegal jumps, one-entry output register.
module gray_binary #(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     g,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     b,
  output logic [1:0]           dir,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {NOPREV, TRACK} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] dec_b, prev_g, prev_b, diff;
  logic             single;
  logic [1:0]       dir_nxt;
  logic             err_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_b = '0;
    dec_b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) dec_b[i] = dec_b[i+1] ^ g[i];
  end

  // Exactly one bit flipped: nonzero and a power of two.
  assign diff   = g ^ prev_g;
  assign single = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  always_comb begin
    state_nxt = state;
    dir_nxt   = 2'b00;
    err_nxt   = 1'b0;
    if (accept) begin
      state_nxt = TRACK;
      if (state == TRACK && diff != '0) begin
        if (single && dec_b == prev_b + WIDTH'(1))      dir_nxt = 2'b01;
        else if (single && dec_b == prev_b - WIDTH'(1)) dir_nxt = 2'b10;
        else begin
          dir_nxt = 2'b11;
          err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NOPREV;
    else     state <= state_nxt;
  end

  // Reference follows every accept, illegal ones included, so checking resyncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_g <= '0;
      prev_b <= '0;
    end else if (accept) begin
      prev_g <= g;
      prev_b <= dec_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      b         <= '0;
      dir       <= 2'b00;
      step_err  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      b         <= dec_b;
      dir       <= dir_nxt;
      step_err  <= err_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     err_count <= '0;
    else if (accept && err_nxt && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_gray_binary.sv
// Bench for gray_binary: directed sequences on a 2-bit instance, randomized
// traffic with backpressure on a 5-bit instance against a step-classification model.
module tb_gray_binary;

  localparam int W  = 5;
  localparam int E  = 3;
  localparam int CMAX = (1 << E) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // narrow instance (WIDTH=2, ERR_CNT_W=2)
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_step_err;
  logic [1:0] n_g, n_b, n_dir, n_err;

  // wide instance
  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_step_err;
  logic [W-1:0] w_g, w_b;
  logic [1:0]   w_dir;
  logic [E-1:0] w_err;

  gray_binary #(.WIDTH(2), .ERR_CNT_W(2)) u_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .g(n_g),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .b(n_b), .dir(n_dir),
    .step_err(n_step_err), .err_count(n_err));

  gray_binary #(.WIDTH(W), .ERR_CNT_W(E)) u_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .g(w_g),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .b(w_b), .dir(w_dir),
    .step_err(w_step_err), .err_count(w_err));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_n(input string tag, input logic [1:0] eb, input logic [1:0] ed,
                       input logic es, input logic [1:0] ec);
    chk({tag, ".valid"}, n_out_valid, 1'b1);
    chk({tag, ".b"},     n_b,         eb);
    chk({tag, ".dir"},   n_dir,       ed);
    chk({tag, ".err"},   n_step_err,  es);
    chk({tag, ".cnt"},   n_err,       ec);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [1:0] gg);
    n_in_valid = 1'b1;
    n_g        = gg;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    n_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] gg);
    logic [W-1:0] r = gg;
    for (int s = 1; s < W; s++) r ^= gg >> s;
    return r;
  endfunction

  logic [1:0] nb_seq [5];
  logic [1:0] nd_seq [5];
  logic [1:0] ng_seq [5];

  // wide model state
  logic         m_valid, m_have, m_err;
  logic [W-1:0] m_b, m_prev, cur_b, bb, df;
  logic [1:0]   m_dir;
  int           m_cnt;
  logic         acc;

  initial begin
    rst = 1'b1;
    n_in_valid = 0; n_g = 0; n_out_ready = 1;
    w_in_valid = 0; w_g = 0; w_out_ready = 1;
    @(negedge clk);
    chk("rst.valid", n_out_valid, 0);
    chk("rst.b",     n_b, 0);
    chk("rst.dir",   n_dir, 0);
    chk("rst.err",   n_step_err, 0);
    chk("rst.cnt",   n_err, 0);
    chk("rst.ready", n_in_ready, 1);
    rst = 1'b0;

    // up run with wrap, back-to-back
    ng_seq = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    nb_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    nd_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 5; i++) begin
      push(ng_seq[i]);
      exp_n($sformatf("up%0d", i), nb_seq[i], nd_seq[i], 1'b0, 2'd0);
    end
    pulse_rst();

    // down run
    ng_seq[0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
    nb_seq[0:3] = '{2'd3, 2'd2, 2'd1, 2'd0};
    nd_seq[0:3] = '{2'b00, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      push(ng_seq[i]);
      exp_n($sformatf("dn%0d", i), nb_seq[i], nd_seq[i], 1'b0, 2'd0);
    end
    pulse_rst();

    // illegal jump then resync
    push(2'b00); exp_n("jmp0", 2'd0, 2'b00, 0, 0);
    push(2'b11); exp_n("jmp1", 2'd2, 2'b11, 1, 1);
    push(2'b10); exp_n("jmp2", 2'd3, 2'b01, 0, 1);
    pulse_rst();

    // backpressure
    n_out_ready = 1'b0;
    push(2'b01);
    n_g = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", n_out_valid, 1);
      chk("bp.ready", n_in_ready, 0);
      chk("bp.b",     n_b, 2'd1);
      @(negedge clk);
    end
    n_out_ready = 1'b1;
    #1 chk("bp.ready_comb", n_in_ready, 1);
    @(negedge clk);
    exp_n("bp.next", 2'd2, 2'b01, 0, 0);
    n_in_valid = 1'b0;
    @(negedge clk);
    chk("bp.drain", n_out_valid, 0);
    pulse_rst();

    // saturation of a 2-bit error counter
    for (int i = 0; i < 6; i++) begin
      push(i[0] ? 2'b11 : 2'b00);
      chk($sformatf("sat%0d", i), n_err, (i > 3) ? 3 : i);
    end
    pulse_rst();

    // reset mid-stream discards the pending sample
    push(2'b01);
    push(2'b11);
    n_in_valid = 1'b0; n_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid.valid", n_out_valid, 0);
    chk("mid.b",     n_b, 0);
    chk("mid.ready", n_in_ready, 1);
    @(negedge clk);
    rst = 1'b0; n_out_ready = 1'b1;
    push(2'b10);
    exp_n("mid.first", 2'd3, 2'b00, 0, 0);
    n_in_valid = 1'b0;

    // randomized traffic on the wide instance
    pulse_rst();
    m_valid = 0; m_have = 0; m_b = 0; m_dir = 0; m_err = 0; m_cnt = 0; m_prev = 0; cur_b = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.valid", w_out_valid, m_valid);
      chk("rnd.cnt",   w_err, m_cnt);
      if (m_valid) begin
        chk("rnd.b",   w_b, m_b);
        chk("rnd.dir", w_dir, m_dir);
        chk("rnd.err", w_step_err, m_err);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cur_b = cur_b + 1'b1;
        4, 5, 6:    cur_b = cur_b - 1'b1;
        7:          ;
        default:    cur_b = W'($urandom);
      endcase
      w_g         = cur_b ^ (cur_b >> 1);
      w_in_valid  = ($urandom_range(0, 3) != 0);
      w_out_ready = ($urandom_range(0, 2) != 0);
      #1 chk("rnd.ready", w_in_ready, !m_valid || w_out_ready);
      acc = w_in_valid && (!m_valid || w_out_ready);
      if (acc) begin
        bb = gray2bin(w_g);
        df = bb - m_prev;
        if (!m_have || df == 0)  m_dir = 2'b00;
        else if (df == 1)        m_dir = 2'b01;
        else if (df == {W{1'b1}}) m_dir = 2'b10;
        else                     m_dir = 2'b11;
        m_err = (m_dir == 2'b11);
        if (m_err && m_cnt < CMAX) m_cnt++;
        m_prev = bb; m_have = 1; m_b = bb; m_valid = 1;
      end else if (w_out_ready) begin
        m_valid = 0;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
